// File: rtl/regfile_dump_pkg.sv
// Shared definitions for the register-file debug dump engine: FSM state
// encodings and the data/address widths shared with the register file.
package regfile_dump_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;
  localparam int NREGS_DEF  = 1 << ADDR_W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage : regfile_dump_pkg

// File: rtl/regfile_dump_if.sv
// Valid/ready stream carrying one dumped register word and its index
// from the dump engine (master) to the debug consumer (slave).
interface regfile_dump_if #(
  parameter int DATA_W = regfile_dump_pkg::DATA_W_DEF,
  parameter int ADDR_W = regfile_dump_pkg::ADDR_W_DEF
);

  logic [DATA_W-1:0] dout;
  logic [ADDR_W-1:0] dout_addr;
  logic              valid;
  logic              ready;

  modport master (
    output dout,
    output dout_addr,
    output valid,
    input  ready
  );

  modport slave (
    input  dout,
    input  dout_addr,
    input  valid,
    output ready
  );

endinterface : regfile_dump_if

// File: rtl/regfile_dump_idx_counter.sv
// Register index counter for the dump walk: synchronous active-low clear,
// increment enable, and a flag marking the last register.
module idx_counter #(
  parameter int ADDR_W = regfile_dump_pkg::ADDR_W_DEF,
  parameter int NREGS  = regfile_dump_pkg::NREGS_DEF
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              inc,
  output logic [ADDR_W-1:0] idx,
  output logic              last
);

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      idx <= '0;
    end else if (inc) begin
      idx <= idx + 1'b1;
    end
  end

  assign last = (idx == ADDR_W'(NREGS - 1));

endmodule : idx_counter

// File: rtl/regfile_dump.sv
// Debug read-out engine: walks every register through a spare combinational
// read port, snapshots each word and streams it out over valid/ready.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREGS  = NREGS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] rd,
  output logic              busy,
  output logic              done,
  regfile_dump_if.master    dbg
);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] ra_nx;
  logic              last;
  logic              inc;
  logic              clr_n;
  logic [DATA_W-1:0] dout_q;
  logic [ADDR_W-1:0] dout_addr_q;

  // The counter returns to zero on reset and while leaving DONE, so every
  // dump starts at register 0 and an abandoned dump leaves no residue.
  assign clr_n = rst && (state != ST_DONE);

  idx_counter #(
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_idx (
    .clk   (clk),
    .clr_n (clr_n),
    .inc   (inc),
    .idx   (idx),
    .last  (last)
  );

  // NOTE: every signal driven here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_nx = state;
    inc      = 1'b0;
    unique case (state)
      ST_IDLE: if (start) state_nx = ST_LOAD;
      ST_LOAD: state_nx = ST_SEND;
      ST_SEND: begin
        if (dbg.ready) begin
          if (last) begin
            state_nx = ST_DONE;
          end else begin
            inc      = 1'b1;
            state_nx = ST_LOAD;
          end
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // ra is registered: it is loaded with the index about to be read one edge
  // ahead of LOAD, so rd has a full cycle to settle before capture.
  always_comb begin
    ra_nx = ra;
    if (state_nx == ST_LOAD) begin
      ra_nx = inc ? ADDR_W'(idx + 1'b1) : idx;
    end else if (state_nx == ST_IDLE) begin
      ra_nx = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      ra          <= '0;
      dout_q      <= '0;
      dout_addr_q <= '0;
    end else begin
      state <= state_nx;
      ra    <= ra_nx;
      if (state == ST_LOAD) begin
        dout_q      <= rd;
        dout_addr_q <= idx;
      end
    end
  end

  // Status outputs decode the state register only, so they carry no
  // combinational path from ready or start.
  assign dbg.valid     = (state == ST_SEND);
  assign dbg.dout      = dout_q;
  assign dbg.dout_addr = dout_addr_q;
  assign busy          = (state != ST_IDLE);
  assign done          = (state == ST_DONE);

endmodule : regfile_dump

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: table-driven dumps against a
// register-file model, plus reset and mid-dump-reset sequences.
module tb_regfile_dump;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [2:0] ra;
  logic [7:0] rd;
  logic       busy;
  logic       done;

  logic [7:0] regs [8];
  logic [7:0] exp_regs [8];

  int checks = 0;
  int errors = 0;
  int accepted = 0;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [7:0] base;
    logic [7:0] step;
    int         stall_word;
    int         stall_n;
    int         poke_word;
    int         wr_at;
    int         wr_reg;
    logic [7:0] wr_val;
    int         exp_done;
  } vec_t;

  regfile_dump_if #(.DATA_W(8), .ADDR_W(3)) dbg ();

  regfile_dump #(.DATA_W(8), .ADDR_W(3), .NREGS(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .ra    (ra),
    .rd    (rd),
    .busy  (busy),
    .done  (done),
    .dbg   (dbg)
  );

  always #5 clk = ~clk;

  assign rd = regs[ra];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: each handshake seen pops the next expected word.
  always @(negedge clk) begin
    if (rst && dbg.valid && dbg.ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got addr %0d data 0x%0h with empty scoreboard",
                 dbg.dout_addr, dbg.dout);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("word_addr", 32'(dbg.dout_addr), 32'(e.addr));
        check("word_data", 32'(dbg.dout), 32'(e.data));
      end
      accepted++;
    end
  end

  // Seed the register model and push the words the dump must deliver. A write
  // made during SEND of an earlier word is seen by that register's later LOAD.
  task automatic seed_and_push(input vec_t v);
    for (int i = 0; i < 8; i++) begin
      regs[i]     = 8'(v.base + v.step * 8'(i));
      exp_regs[i] = regs[i];
      if (v.wr_at >= 0 && v.wr_reg == i && v.wr_at < i) exp_regs[i] = v.wr_val;
      sb.push_back('{addr: 3'(i), data: exp_regs[i]});
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge following the
  // cycle in which done was seen.
  task automatic run_dump(input vec_t v);
    int cyc = 0;
    int stalled = 0;
    int done_cyc = -1;
    int ndone = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    while (cyc < 100 && !(done_cyc >= 0 && cyc > done_cyc)) begin
      cyc++;
      if (cyc == 1) begin
        check("busy_after_start", 32'(busy), 32'd1);
        check("valid_in_load", 32'(dbg.valid), 32'd0);
      end
      if (cyc == 2) check("valid_second_cycle", 32'(dbg.valid), 32'd1);
      dbg.ready = 1'b1;
      start     = 1'b0;
      if (dbg.valid && dbg.dout_addr == v.stall_word && stalled < v.stall_n) begin
        dbg.ready = 1'b0;
        stalled++;
        check("stall_data", 32'(dbg.dout), 32'(exp_regs[v.stall_word]));
        check("stall_addr", 32'(dbg.dout_addr), 32'(v.stall_word));
      end
      if (dbg.valid && dbg.dout_addr == v.poke_word) start = 1'b1;
      if (dbg.valid && dbg.dout_addr == v.wr_at) regs[v.wr_reg] = v.wr_val;
      @(negedge clk);
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      @(posedge clk);
      #1;
    end
    start     = 1'b0;
    dbg.ready = 1'b1;
    check("done_cycle", 32'(done_cyc), 32'(v.exp_done));
    check("done_count", 32'(ndone), 32'd1);
    check("busy_after_done", 32'(busy), 32'd0);
    check("done_one_wide", 32'(done), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    vec_t vecs[7];
    vecs[0] = '{base:8'h00, step:8'h11, stall_word:-1, stall_n:0, poke_word:-1,
                wr_at:-1, wr_reg:0, wr_val:8'h00, exp_done:17};
    vecs[1] = '{base:8'h00, step:8'h11, stall_word:3, stall_n:5, poke_word:-1,
                wr_at:-1, wr_reg:0, wr_val:8'h00, exp_done:22};
    vecs[2] = '{base:8'h00, step:8'h11, stall_word:-1, stall_n:0, poke_word:2,
                wr_at:-1, wr_reg:0, wr_val:8'h00, exp_done:17};
    vecs[3] = '{base:8'h00, step:8'h11, stall_word:-1, stall_n:0, poke_word:-1,
                wr_at:2, wr_reg:5, wr_val:8'hA5, exp_done:17};
    vecs[4] = '{base:8'h00, step:8'h11, stall_word:-1, stall_n:0, poke_word:-1,
                wr_at:1, wr_reg:1, wr_val:8'hFF, exp_done:17};
    vecs[5] = '{base:8'hF0, step:8'h03, stall_word:0, stall_n:2, poke_word:-1,
                wr_at:-1, wr_reg:0, wr_val:8'h00, exp_done:19};
    vecs[6] = '{base:8'h80, step:8'h25, stall_word:7, stall_n:3, poke_word:-1,
                wr_at:-1, wr_reg:0, wr_val:8'h00, exp_done:20};

    for (int i = 0; i < 8; i++) regs[i] = 8'h00;
    dbg.ready = 1'b1;

    // Reset held two cycles with start high: everything must stay quiet.
    rst   = 1'b0;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ra", 32'(ra), 32'd0);
    check("rst_dout", 32'(dbg.dout), 32'd0);
    check("rst_dout_addr", 32'(dbg.dout_addr), 32'd0);
    check("rst_valid", 32'(dbg.valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    start = 1'b0;
    rst   = 1'b1;
    @(posedge clk);
    #1;
    check("idle_busy", 32'(busy), 32'd0);

    for (int v = 0; v < 7; v++) begin
      seed_and_push(vecs[v]);
      run_dump(vecs[v]);
      repeat (2) @(posedge clk);
      #1;
    end

    // Reset after word 4 is accepted: dump abandoned, no done.
    begin
      int k = 0;
      int ndone = 0;
      seed_and_push(vecs[0]);
      accepted = 0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      while (accepted < 5 && k < 40) begin
        k++;
        @(posedge clk);
        #1;
      end
      check("midrst_reached_word4", 32'(accepted), 32'd5);
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_valid", 32'(dbg.valid), 32'd0);
      check("midrst_dout", 32'(dbg.dout), 32'd0);
      check("midrst_dout_addr", 32'(dbg.dout_addr), 32'd0);
      check("midrst_ra", 32'(ra), 32'd0);
      check("midrst_pending", 32'(sb.size()), 32'd3);
      sb.delete();
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (done) ndone++;
      end
      @(posedge clk);
      #1;
      check("midrst_no_done", 32'(ndone), 32'd0);
      seed_and_push(vecs[0]);
      run_dump(vecs[0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule : tb_regfile_dump

// File: doc/regfile_dump.md
# regfile_dump

Debug read-out engine for the 8-bit CPU register file: on a `start` pulse it walks read addresses 0..NREGS-1 through the file's combinational read port, captures each word, and streams it out over a valid/ready handshake to a debug consumer (UART/bridge), then pulses `done`. It is the read-side counterpart of the decoder-driven write path: it only reads and never drives `we`/`wd3`. It sits beside the register file on a spare read port.

## Interface
Parameters:
- `DATA_W`, 8, register width
- `ADDR_W`, 3, register address width
- `NREGS`, 8, registers dumped; must equal 2**ADDR_W

Ports:
- `clk` in 1: sole clock, rising edge
- `rst` in 1: reset; synchronous, active-low (sampled only on rising `clk`)
- `start` in 1: begin dump; honoured only in IDLE
- `ra` out ADDR_W: read address to register-file read mux
- `rd` in DATA_W: combinational read data for `ra`
- `dout` out DATA_W: captured register value
- `dout_addr` out ADDR_W: index of `dout`
- `valid` out 1: `dout`/`dout_addr` valid
- `ready` in 1: consumer accepts when `valid && ready` at rising edge
- `busy` out 1: dump in progress (any state but IDLE)
- `done` out 1: one-cycle pulse after last word accepted

## Operation
- States: IDLE, LOAD, SEND, DONE; index counter `idx` (ADDR_W bits).
- IDLE: `ra`=0, `idx`=0. `start`=1 -> LOAD.
- LOAD: `ra`=`idx`; at edge `dout`<=`rd`, `dout_addr`<=`idx`; -> SEND.
- SEND: `valid`=1; `dout`/`dout_addr` held stable until handshake. On `valid && ready`: if `idx`==NREGS-1 -> DONE, else `idx`<=`idx`+1 -> LOAD. No handshake -> stay SEND indefinitely.
- DONE: `done`=1 one cycle; `idx`<=0; -> IDLE.
- `valid`, `busy`, `done` decoded from state register only (glitch-free, no combinational path from `ready`/`start`).
- `start` in LOAD/SEND/DONE ignored (no queuing). `start` held high continuously -> back-to-back dumps, one IDLE cycle between them.
- `idx` never wraps within a dump; final increment suppressed at NREGS-1.
- Data is a per-word snapshot taken in LOAD; a CPU write to register k after its LOAD is not reflected. Register file writes are not blocked.
- `rst`=0 at any edge, including mid-dump: -> IDLE, `idx`=0; partially sent dump is abandoned, no `done`.

## Timing
- Reset values: `ra`=0, `dout`=0, `dout_addr`=0, `valid`=0, `busy`=0, `done`=0.
- `start` sampled at edge E0 -> LOAD in cycle after E0 (`busy`=1), `valid`=1 from second cycle after E0.
- Per word: 1 LOAD + ≥1 SEND cycles; with `ready` tied high, 2 cycles/word.
- Full dump with `ready`=1: `done` high in cycle 17 after E0 (16 cycles data + DONE); `busy` falls with `done`.
- `ra` is registered; `rd` must settle within one cycle (combinational mux path).

## Structure
- Shared package/include: state encodings (IDLE=0, LOAD=1, SEND=2, DONE=3, 2-bit), `DATA_W`/`ADDR_W` defaults shared with register file.
- One sub-module natural: `idx_counter` — ADDR_W-bit counter with synchronous active-low clear, increment enable, and `last` flag (`idx`==NREGS-1).
- FSM, capture registers and output decode in top level.

## Test plan
- Reset: drive `rst`=0 two cycles with `start`=1 -> all outputs 0, no `busy`.
- Full dump, `ready`=1, regs R0..R7 = 0x00,0x11,...,0x77 -> eight handshakes with (`dout_addr`,`dout`) = (0,0x00)..(7,0x77), `done` exactly 17 cycles after `start` edge, one cycle wide.
- Backpressure: `ready`=0 for 5 cycles on word 3 (0x33) -> `valid` held, `dout`=0x33/`dout_addr`=3 stable all 5 cycles, word 4 follows after release.
- `start` pulsed during SEND of word 2 -> ignored; exactly eight words and one `done`.
- Reset mid-dump after word 4 accepted -> next cycle IDLE, outputs reset, no `done`; new `start` restarts from R0=0x00.
- Snapshot: write R5=0xA5 while word 2 in SEND -> word 5 reads 0xA5; write R1=0xFF after word 1 LOAD -> word 1 still 0x11.
